// File: rtl/mips32_pkg.sv
// Shared definitions for the pipe_mips32 integer pipeline and its hazard scheduler.
// Contents: register address width, HLT opcode, in-flight tracker entry type and
// a helper that decides whether an entry represents a trackable GPR write.
package mips32_pkg;

    localparam int unsigned AW     = 5;
    localparam int unsigned NREG   = 1 << AW;
    localparam logic [5:0]  OP_HLT = 6'h3f;

    // One in-flight pipeline slot (EX, MEM or WB)
    typedef struct packed {
        logic          valid;
        logic          wr;
        logic [AW-1:0] rd;
        logic          halt;
    } inflight_t;

    // A write to R0 is architecturally discarded, so it never creates a dependency
    function automatic logic is_pending(input inflight_t e);
        return e.valid & e.wr & (e.rd != '0);
    endfunction

endpackage

// File: rtl/mips32_inflight_tracker.sv
// Three-stage shadow of the EX/MEM/WB destination fields.
// Ports:
//   clk1, rst_n                      clock, synchronous active-low reset
//   in_valid/in_wr/in_rd/in_halt     entry loaded into EX (in_valid=0 loads an empty slot)
//   rs, rt                           source registers to compare against pending writes
//   match_rs, match_rt               source hits a pending write (WB only when WB_BYPASS=0)
//   pend_mask                        one bit per GPR with a pending write in EX, MEM or WB
//   wb_halt                          the WB slot holds an HLT
module mips32_inflight_tracker
    import mips32_pkg::*;
#(
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            in_wr,
    input  logic [AW-1:0]   in_rd,
    input  logic            in_halt,
    input  logic [AW-1:0]   rs,
    input  logic [AW-1:0]   rt,
    output logic            match_rs,
    output logic            match_rt,
    output logic [NREG-1:0] pend_mask,
    output logic            wb_halt
);

    inflight_t ex_q;
    inflight_t mem_q;
    inflight_t wb_q;
    inflight_t ex_in;

    // Empty slot when nothing issues so stale fields never look pending
    always_comb begin
        ex_in = '0;
        if (in_valid) begin
            ex_in.valid = 1'b1;
            ex_in.wr    = in_wr;
            ex_in.rd    = in_rd;
            ex_in.halt  = in_halt;
        end
    end

    // Shift register: advances every cycle
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            wb_q  <= mem_q;
            mem_q <= ex_q;
            ex_q  <= ex_in;
        end
    end

    function automatic logic hit(input inflight_t e, input logic [AW-1:0] x);
        return is_pending(e) && (e.rd == x);
    endfunction

    // WB is ignored when the register file writes before it reads
    function automatic logic src_match(input logic [AW-1:0] x);
        return (x != '0) && (hit(ex_q, x) || hit(mem_q, x) || (!WB_BYPASS && hit(wb_q, x)));
    endfunction

    assign match_rs = src_match(rs);
    assign match_rt = src_match(rt);
    assign wb_halt  = wb_q.valid & wb_q.halt;

    // Debug view of every tracked write, independent of the bypass setting
    always_comb begin
        pend_mask = '0;
        if (is_pending(ex_q))  pend_mask[ex_q.rd]  = 1'b1;
        if (is_pending(mem_q)) pend_mask[mem_q.rd] = 1'b1;
        if (is_pending(wb_q))  pend_mask[wb_q.rd]  = 1'b1;
    end

endmodule

// File: rtl/mips32_hazard_scheduler.sv
// In-order issue scheduler for the 5-stage pipe_mips32 pipeline: stalls ID on a
// read-after-write hazard against EX/MEM(/WB), squashes ID on a taken branch and
// blocks all issue once HLT has issued, reporting halted when HLT reaches WB.
// Ports:
//   clk1, rst_n                  clock, synchronous active-low reset
//   id_*                         decoded fields of the instruction in ID
//   branch_taken                 ID instruction is wrong-path this cycle
//   stall, bubble, issue         combinational pipeline controls
//   halted                       registered, HLT has drained to WB
//   pend_mask                    debug mask of tracked GPR writes
//   stall_cycles                 saturating hazard-stall cycle count
module mips32_hazard_scheduler
    import mips32_pkg::*;
#(
    parameter bit          WB_BYPASS = 1'b1,
    parameter int unsigned CW        = 16
) (
    input  logic            clk1,
    input  logic            rst_n,
    input  logic            id_valid,
    input  logic            id_rs_used,
    input  logic            id_rt_used,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_halt,
    input  logic            branch_taken,
    output logic            stall,
    output logic            bubble,
    output logic            issue,
    output logic            halted,
    output logic [NREG-1:0] pend_mask,
    output logic [CW-1:0]   stall_cycles
);

    logic match_rs;
    logic match_rt;
    logic wb_halt;
    logic hazard;
    logic halt_seen;

    mips32_inflight_tracker #(
        .WB_BYPASS (WB_BYPASS)
    ) u_tracker (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .in_valid  (issue),
        .in_wr     (id_wr_en),
        .in_rd     (id_rd),
        .in_halt   (id_halt),
        .rs        (id_rs),
        .rt        (id_rt),
        .match_rs  (match_rs),
        .match_rt  (match_rt),
        .pend_mask (pend_mask),
        .wb_halt   (wb_halt)
    );

    // Squash takes priority: a wrong-path instruction never raises a hazard
    assign hazard = id_valid & ~branch_taken &
                    ((id_rs_used & match_rs) | (id_rt_used & match_rt));
    assign stall  = hazard | halt_seen;
    // Nothing issues while reset is asserted, so the tracker stays empty
    assign issue  = rst_n & id_valid & ~branch_taken & ~stall;
    assign bubble = ~issue;

    // Halt bookkeeping and saturating stall counter
    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            halt_seen    <= 1'b0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            halt_seen <= halt_seen | (issue & id_halt);
            halted    <= halted | wb_halt;
            if (hazard && !halt_seen && (stall_cycles != {CW{1'b1}})) begin
                stall_cycles <= stall_cycles + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mips32_hazard_scheduler.sv
// Scoreboard bench: two schedulers (WB_BYPASS=1 and 0) share stimulus; a
// distance-since-issue reference model predicts every cycle's outputs.
module tb_mips32_hazard_scheduler;
    import mips32_pkg::*;

    localparam int unsigned CW = 16;

    typedef struct packed {
        logic            stall;
        logic            bubble;
        logic            issue;
        logic            halted;
        logic [31:0]     pend;
        logic [CW-1:0]   cnt;
    } exp_t;

    logic clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    logic          rst_n;
    logic          id_valid, id_rs_used, id_rt_used, id_wr_en, id_halt, branch_taken;
    logic [AW-1:0] id_rs, id_rt, id_rd;

    logic          stall_o  [2];
    logic          bubble_o [2];
    logic          issue_o  [2];
    logic          halted_o [2];
    logic [31:0]   pend_o   [2];
    logic [CW-1:0] cnt_o    [2];

    mips32_hazard_scheduler #(.WB_BYPASS(1'b1), .CW(CW)) dut_byp (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_halt(id_halt), .branch_taken(branch_taken),
        .stall(stall_o[0]), .bubble(bubble_o[0]), .issue(issue_o[0]),
        .halted(halted_o[0]), .pend_mask(pend_o[0]), .stall_cycles(cnt_o[0]));

    mips32_hazard_scheduler #(.WB_BYPASS(1'b0), .CW(CW)) dut_nobyp (
        .clk1(clk1), .rst_n(rst_n), .id_valid(id_valid), .id_rs_used(id_rs_used),
        .id_rt_used(id_rt_used), .id_rs(id_rs), .id_rt(id_rt), .id_wr_en(id_wr_en),
        .id_rd(id_rd), .id_halt(id_halt), .branch_taken(branch_taken),
        .stall(stall_o[1]), .bubble(bubble_o[1]), .issue(issue_o[1]),
        .halted(halted_o[1]), .pend_mask(pend_o[1]), .stall_cycles(cnt_o[1]));

    exp_t q0[$];
    exp_t q1[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model: cycle index of the latest issued write per register,
    // cycle HLT issued (-1 = none), and hazard-stall count.
    longint last_wr [2][32];
    longint halt_cyc[2];
    int     cnt     [2];
    longint cyc = 0;

    task automatic model_clear(input int m);
        for (int r = 0; r < 32; r++) last_wr[m][r] = -100;
        halt_cyc[m] = -1;
        cnt[m]      = 0;
    endtask

    // Producer issued d cycles ago sits in EX (1), MEM (2) or WB (3)
    function automatic logic src_hit(input int m, input logic [4:0] r);
        longint d;
        d = cyc - last_wr[m][r];
        if (r == 5'd0) return 1'b0;
        return (d == 1) || (d == 2) || ((m == 1) && (d == 3));
    endfunction

    task automatic drive(input logic rst, input logic v, input logic rsu, input logic rtu,
                         input logic [4:0] rs, input logic [4:0] rt, input logic wr,
                         input logic [4:0] rd, input logic [5:0] op, input logic br);
        exp_t e;
        logic hs, hz;
        longint d;
        @(posedge clk1);
        #1;
        rst_n = rst; id_valid = v; id_rs_used = rsu; id_rt_used = rtu;
        id_rs = rs; id_rt = rt; id_wr_en = wr; id_rd = rd;
        id_halt = (op == OP_HLT); branch_taken = br;
        for (int m = 0; m < 2; m++) begin
            hs = (halt_cyc[m] >= 0);
            hz = v & ~br & ((rsu & src_hit(m, rs)) | (rtu & src_hit(m, rt)));
            e.stall  = hz | hs;
            e.issue  = rst & v & ~br & ~e.stall;
            e.bubble = ~e.issue;
            e.halted = hs && (cyc >= halt_cyc[m] + 4);
            e.pend   = '0;
            for (int r = 1; r < 32; r++) begin
                d = cyc - last_wr[m][r];
                if (d >= 1 && d <= 3) e.pend[r] = 1'b1;
            end
            e.cnt = CW'(cnt[m]);
            if (m == 0) q0.push_back(e); else q1.push_back(e);
            // state after this cycle's edge
            if (!rst) begin
                model_clear(m);
            end else begin
                if (hz && !hs && cnt[m] < 65535) cnt[m]++;
                if (e.issue) begin
                    if (wr && rd != 5'd0) last_wr[m][rd] = cyc;
                    if (op == OP_HLT) halt_cyc[m] = cyc;
                end
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
    endtask

    task automatic inst(input logic rsu, input logic rtu, input logic [4:0] rs,
                        input logic [4:0] rt, input logic wr, input logic [4:0] rd);
        drive(1, 1, rsu, rtu, rs, rt, wr, rd, 6'd0, 0);
    endtask

    task automatic chk(input int m, input string nm, input logic [31:0] a, input logic [31:0] x);
        n_cmp++;
        if (a !== x) begin
            n_fail++;
            $display("FAIL dut%0d %s t=%0t actual=%0h required=%0h", m, nm, $time, a, x);
        end
    endtask

    task automatic check_all(input int m, input exp_t e);
        chk(m, "stall",        32'(stall_o[m]),  32'(e.stall));
        chk(m, "bubble",       32'(bubble_o[m]), 32'(e.bubble));
        chk(m, "issue",        32'(issue_o[m]),  32'(e.issue));
        chk(m, "halted",       32'(halted_o[m]), 32'(e.halted));
        chk(m, "pend_mask",    pend_o[m],        e.pend);
        chk(m, "stall_cycles", 32'(cnt_o[m]),    32'(e.cnt));
    endtask

    // Monitors: pop and compare once per cycle, away from the active edge
    always @(negedge clk1) begin : mon0
        exp_t e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            check_all(0, e);
        end
    end

    always @(negedge clk1) begin : mon1
        exp_t e;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            check_all(1, e);
        end
    end

    initial begin
        logic rst, v, rsu, rtu, wr, br;
        logic [4:0] rs, rt, rd;
        logic [5:0] op;
        model_clear(0);
        model_clear(1);
        rst_n = 0; id_valid = 0; id_rs_used = 0; id_rt_used = 0; id_rs = '0; id_rt = '0;
        id_wr_en = 0; id_rd = '0; id_halt = 0; branch_taken = 0;
        repeat (2) @(posedge clk1);

        // reset state
        idle(2);
        // ADDI R1,R0,10 ; ADD R4,R1,R2 held in ID
        inst(1, 0, 0, 0, 1, 1);
        repeat (4) inst(1, 1, 1, 2, 1, 4);
        idle(4);
        // writes to R0 are never tracked
        inst(1, 0, 0, 0, 1, 0);
        inst(1, 1, 0, 0, 1, 4);
        idle(3);
        // one independent spacer removes one stall cycle
        inst(1, 0, 0, 0, 1, 1);
        inst(1, 1, 7, 7, 1, 7);
        repeat (3) inst(1, 1, 1, 2, 1, 4);
        idle(4);
        // unused rt field does not create a hazard
        inst(1, 0, 0, 0, 1, 1);
        inst(1, 0, 2, 1, 1, 4);
        idle(4);
        // squash beats hazard
        inst(1, 0, 0, 0, 1, 1);
        drive(1, 1, 1, 1, 1, 2, 1, 4, 6'd0, 1);
        idle(4);
        // reset during a stall
        inst(1, 0, 0, 0, 1, 1);
        inst(1, 1, 1, 2, 1, 4);
        drive(0, 1, 1, 1, 1, 2, 1, 4, 6'd0, 0);
        inst(1, 1, 1, 2, 1, 4);
        idle(3);
        // ADDI R1 ; HLT ; dependent instructions never issue
        inst(1, 0, 0, 0, 1, 1);
        drive(1, 1, 0, 0, 0, 0, 0, 0, OP_HLT, 0);
        repeat (6) inst(1, 1, 1, 2, 1, 4);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 6'd0, 0);
        idle(1);

        // randomized traffic with occasional resets and halts
        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(0, 79) != 0);
            if (halt_cyc[0] >= 0 && cyc > halt_cyc[0] + 8) rst = 1'b0;
            v   = ($urandom_range(0, 4) != 0);
            rsu = 1'($urandom);
            rtu = 1'($urandom);
            rs  = 5'($urandom_range(0, 7));
            rt  = 5'($urandom_range(0, 7));
            wr  = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 7));
            op  = ($urandom_range(0, 39) == 0) ? OP_HLT : 6'h00;
            br  = ($urandom_range(0, 9) == 0);
            drive(rst, v, rsu, rtu, rs, rt, wr, rd, op, br);
        end

        @(negedge clk1);
        #1;
        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual=%0d/%0d required=0/0", q0.size(), q1.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
